// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer: owns a small 4-bit register file, feeds a combinational 4-bit ALU
// and returns each result over a valid/ready response. Optional zero flag: ALUSEQ_ZERO_FLAG_EN.
module alu_op_sequencer #(
  parameter int unsigned NReg = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_load_i,
  input  logic [2:0] cmd_op_i,
  input  logic [1:0] cmd_ra_i,
  input  logic [1:0] cmd_rb_i,
  input  logic [1:0] cmd_rd_i,
  input  logic [3:0] cmd_imm_i,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic       alu_bin_o,
  output logic [1:0] alu_oper_o,
  input  logic [3:0] alu_res_i,
  input  logic       alu_carout_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [3:0] rsp_data_o,
  output logic       rsp_carry_o
`ifdef ALUSEQ_ZERO_FLAG_EN
  ,
  output logic       rsp_zero_o
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q;
  logic [3:0] rf_q [NReg];
  logic [3:0] alu_a_q, alu_b_q;
  logic [2:0] op_q;
  logic [1:0] rd_q;
  logic [3:0] rsp_data_q;
  logic       rsp_carry_q;
`ifdef ALUSEQ_ZERO_FLAG_EN
  logic       rsp_zero_q;
`endif

  logic [3:0] rd_a, rd_b;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;

  // Addresses at or beyond NReg read as zero.
  always_comb begin
    rd_a = 4'd0;
    rd_b = 4'd0;
    for (int i = 0; i < int'(NReg); i++) begin
      if (cmd_ra_i == 2'(i)) rd_a = rf_q[i];
      if (cmd_rb_i == 2'(i)) rd_b = rf_q[i];
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cmd_rd_i;
    wr_data = cmd_imm_i;
    if (state_q == StIdle && cmd_valid_i && cmd_load_i) begin
      wr_en = 1'b1;
    end else if (state_q == StExec) begin
      wr_en   = 1'b1;
      wr_addr = rd_q;
      wr_data = alu_res_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      op_q        <= 3'd0;
      rd_q        <= 2'd0;
      rsp_data_q  <= 4'd0;
      rsp_carry_q <= 1'b0;
`ifdef ALUSEQ_ZERO_FLAG_EN
      rsp_zero_q  <= 1'b0;
`endif
      for (int i = 0; i < int'(NReg); i++) rf_q[i] <= 4'd0;
    end else begin
      // Writes to an address at or beyond NReg match no entry and are dropped.
      for (int i = 0; i < int'(NReg); i++) begin
        if (wr_en && wr_addr == 2'(i)) rf_q[i] <= wr_data;
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            if (cmd_load_i) begin
              rsp_data_q  <= cmd_imm_i;
              rsp_carry_q <= 1'b0;
`ifdef ALUSEQ_ZERO_FLAG_EN
              rsp_zero_q  <= (cmd_imm_i == 4'd0);
`endif
              state_q     <= StResp;
            end else begin
              // Operands are captured here, so ra/rb == rd see the pre-write value.
              alu_a_q <= rd_a;
              alu_b_q <= rd_b;
              op_q    <= cmd_op_i;
              rd_q    <= cmd_rd_i;
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          rsp_data_q  <= alu_res_i;
          rsp_carry_q <= alu_carout_i;
`ifdef ALUSEQ_ZERO_FLAG_EN
          rsp_zero_q  <= (alu_res_i == 4'd0);
`endif
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_bin_o   = op_q[2];
  assign alu_oper_o  = op_q[1:0];
  assign rsp_data_o  = rsp_data_q;
  assign rsp_carry_o = rsp_carry_q;
`ifdef ALUSEQ_ZERO_FLAG_EN
  assign rsp_zero_o  = rsp_zero_q;
`endif

endmodule
